router_sync_param: RTL
======================

ROUTER_SYNC_PARAM -- requirements
Module: router_sync_param

Interface
REQ-001 Parameter NUM_CH, default 3, number of destination FIFOs (legal 1..8).
REQ-002 Parameter ADDR_W, default 2, destination-address width; SHALL satisfy 2**ADDR_W >= NUM_CH (elaboration error otherwise).
REQ-003 Parameter TIMEOUT, default 30, stalled-cycle threshold before soft reset (legal 1..2**CNT_W-1).
REQ-004 Parameter CNT_W, default 5, timeout counter width.
REQ-005 clock  input  1  single clock, all state on rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 detect_add  input  1  FSM strobe: capture data_in as destination.
REQ-008 write_enb_reg  input  1  FSM request to write current byte.
REQ-009 data_in  input  ADDR_W  destination address field of header.
REQ-010 read_enb  input  NUM_CH  per-channel reader read strobe.
REQ-011 empty  input  NUM_CH  per-FIFO empty flags.
REQ-012 full  input  NUM_CH  per-FIFO full flags.
REQ-013 clear_status  input  1  clears timeout_sticky.
REQ-014 write_enb  output  NUM_CH  one-hot FIFO write enables.
REQ-015 fifo_full  output  1  full flag of currently addressed FIFO.
REQ-016 vld_out  output  NUM_CH  per-channel data-valid to readers.
REQ-017 soft_reset  output  NUM_CH  per-FIFO timeout flush pulse.
REQ-018 addr_err  output  1  captured address >= NUM_CH.
REQ-019 timeout_sticky  output  NUM_CH  sticky record of timeouts per channel.

Function
REQ-020 fifo_addr register SHALL load data_in on every edge with detect_add=1, else hold.
REQ-021 addr_err register SHALL load (data_in >= NUM_CH) on every edge with detect_add=1, else hold.
REQ-022 write_enb SHALL be combinational: bit fifo_addr set iff write_enb_reg=1 and addr_err=0; all zero otherwise.
REQ-023 Simultaneous detect_add and write_enb_reg: write_enb SHALL decode the pre-edge fifo_addr (no bypass).
REQ-024 fifo_full SHALL be combinational full[fifo_addr] when addr_err=0, else 0.
REQ-025 vld_out[i] SHALL equal ~empty[i], combinational, zero latency.
REQ-026 Channel i stalled = vld_out[i]=1 and read_enb[i]=0.
REQ-027 Per channel counter cnt[i] (CNT_W bits): stalled and cnt!=TIMEOUT -> cnt+1; stalled and cnt==TIMEOUT -> 0; not stalled -> 0.
REQ-028 soft_reset[i] SHALL be registered, high for exactly one cycle after the edge where stalled and cnt==TIMEOUT, i.e. on the (TIMEOUT+1)th consecutive stalled edge; low in every other cycle.
REQ-029 Continued stall after a pulse SHALL restart counting from 0, giving a further pulse every TIMEOUT+1 stalled cycles.
REQ-030 Counter SHALL never wrap; any non-stalled cycle clears it regardless of value.
REQ-031 timeout_sticky[i] SHALL set on the same edge soft_reset[i] is set; clear on edge with clear_status=1; set wins when both coincide.
REQ-032 Channels SHALL operate independently; simultaneous timeouts on several channels all pulse in the same cycle.

Reset
REQ-033 resetn=0 SHALL immediately clear fifo_addr, addr_err, all cnt, soft_reset, timeout_sticky to 0, independent of clock.
REQ-034 Mid-operation reset SHALL abort any count in progress; no soft_reset pulse may appear in the cycle after reset release.
REQ-035 Combinational outputs during reset follow their inputs with fifo_addr=0, addr_err=0.

Structure
REQ-036 Package router_pkg SHALL hold default NUM_CH, ADDR_W, TIMEOUT, CNT_W constants and a clog2 function shared across router blocks.
REQ-037 Per-channel counter, pulse and sticky logic SHALL be sub-module router_sync_timer, instantiated NUM_CH times via generate.

Verification
REQ-038 Defaults; detect_add with data_in=2, then write_enb_reg=1 -> write_enb=3'b100; full=3'b100 -> fifo_full=1.
REQ-039 Defaults; data_in=3 captured -> addr_err=1, write_enb=0, fifo_full=0 while write_enb_reg=1; next data_in=1 capture clears addr_err.
REQ-040 Defaults; empty[0]=0, read_enb[0]=0 held 70 cycles -> soft_reset[0] one-cycle pulse after stalled edges 31 and 62, timeout_sticky[0]=1.
REQ-041 Defaults; stall channel 1 for 30 edges, read_enb[1]=1 for one cycle, stall 30 more -> no soft_reset[1].
REQ-042 NUM_CH=5, ADDR_W=3, TIMEOUT=4; channels 0 and 4 stalled together -> both soft_reset bits pulse on 5th edge; clear_status coincident with pulse -> sticky stays 1.
REQ-043 Assert resetn=0 asynchronously at cnt=20 mid-stall -> all registered outputs 0 without clock edge; after release, first pulse only after 31 new stalled edges.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router constants and elaboration helpers used across router blocks.
package router_pkg;

  localparam int unsigned DEF_NUM_CH  = 3;
  localparam int unsigned DEF_ADDR_W  = 2;
  localparam int unsigned DEF_TIMEOUT = 30;
  localparam int unsigned DEF_CNT_W   = 5;

  // Ceiling log2; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall timer: counts stalled cycles, emits a one-cycle soft reset
// on timeout, and keeps a sticky record until software clears it.
module router_sync_timer
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic clock,
  input  logic resetn,
  input  logic stalled,
  input  logic clear_status,
  output logic soft_reset,
  output logic timeout_sticky
);

  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit = stalled && (cnt == CNT_W'(TIMEOUT));

  // Counter restarts from zero after a timeout and on any non-stalled cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt            <= '0;
      soft_reset     <= 1'b0;
      timeout_sticky <= 1'b0;
    end else begin
      cnt        <= (stalled && !hit) ? cnt + CNT_W'(1) : '0;
      soft_reset <= hit;
      if (hit)               timeout_sticky <= 1'b1;
      else if (clear_status) timeout_sticky <= 1'b0;
    end
  end

endmodule

// File: rtl/router_sync_param.sv
// Router synchroniser: latches the header destination, decodes FIFO write
// enables and full status, and supervises per-channel read stalls.
module router_sync_param
  import router_pkg::*;
#(
  parameter int unsigned NUM_CH  = DEF_NUM_CH,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              write_enb_reg,
  input  logic [ADDR_W-1:0] data_in,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  input  logic              clear_status,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err,
  output logic [NUM_CH-1:0] timeout_sticky
);

  localparam int unsigned CMP_W = ADDR_W + 1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("router_sync_param: NUM_CH must be in 1..8");
  end
  if (ADDR_W < clog2(NUM_CH)) begin : g_bad_addr_w
    $error("router_sync_param: ADDR_W too narrow for NUM_CH");
  end
  if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
    $error("router_sync_param: TIMEOUT must be in 1..2**CNT_W-1");
  end

  logic [ADDR_W-1:0] fifo_addr;

  // Destination capture; the compare is widened so NUM_CH == 2**ADDR_W fits.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fifo_addr <= '0;
      addr_err  <= 1'b0;
    end else if (detect_add) begin
      fifo_addr <= data_in;
      addr_err  <= ({1'b0, data_in} >= CMP_W'(NUM_CH));
    end
  end

  // Decode from the registered address only, so a same-cycle capture never bypasses.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!addr_err && (fifo_addr == ADDR_W'(i))) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    router_sync_timer #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timer (
      .clock          (clock),
      .resetn         (resetn),
      .stalled        (vld_out[i] & ~read_enb[i]),
      .clear_status   (clear_status),
      .soft_reset     (soft_reset[i]),
      .timeout_sticky (timeout_sticky[i])
    );
  end

endmodule
